instr_decode_stage: RTL and testbench

Registered instruction decode stage for the i281 datapath. It accepts 16-bit instruction words from the fetch side over a valid/ready handshake. Each word is decoded into the one-hot opcode vector plus the X/Y/immediate fields that the combinational control unit consumes, and the result is held in a single pipeline register. The stage supports downstream back-pressure, a flush for taken jumps and branches, illegal-encoding flagging, and a decoded-instruction counter.

---
 rtl/instr_decode_stage_if.sv | 32 +++
 rtl/instr_decode_stage.sv | 145 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and the control/execute side.
// The stage itself uses the slave modport; the fetch/consumer side uses master.
interface instr_decode_stage_if #(
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic [15:0]        in_instr;
    logic [7:0]         in_pc;
    logic               in_ready;
    logic               out_ready;
    logic               flush;
    logic               out_valid;
    logic [22:0]        op_vec;
    logic [1:0]         out_x;
    logic [1:0]         out_y;
    logic [7:0]         out_imm;
    logic [7:0]         out_pc;
    logic               out_illegal;
    logic [COUNT_W-1:0] decode_count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, flush,
        input  in_ready, out_valid, op_vec, out_x, out_y, out_imm, out_pc,
               out_illegal, decode_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, flush,
        output in_ready, out_valid, op_vec, out_x, out_y, out_imm, out_pc,
               out_illegal, decode_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// i281 decode stage: decodes a 16-bit word into a one-hot opcode plus X/Y/imm
// fields and holds it in one pipeline register with valid/ready and flush.
module instr_decode_stage #(
    parameter int COUNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_decode_stage_if.slave bus
);
    localparam int OP_NOOP    = 0;
    localparam int OP_INPUTC  = 1;
    localparam int OP_INPUTCF = 2;
    localparam int OP_INPUTD  = 3;
    localparam int OP_INPUTDF = 4;
    localparam int OP_MOVE    = 5;
    localparam int OP_LOADI   = 6;
    localparam int OP_ADD     = 7;
    localparam int OP_ADDI    = 8;
    localparam int OP_SUB     = 9;
    localparam int OP_SUBI    = 10;
    localparam int OP_LOAD    = 11;
    localparam int OP_LOADF   = 12;
    localparam int OP_STORE   = 13;
    localparam int OP_STOREF  = 14;
    localparam int OP_SHIFTL  = 15;
    localparam int OP_SHIFTR  = 16;
    localparam int OP_CMP     = 17;
    localparam int OP_JUMP    = 18;
    localparam int OP_BRE     = 19;
    localparam int OP_BRNE    = 20;
    localparam int OP_BRG     = 21;
    localparam int OP_BRGE    = 22;

    logic [3:0]         w_opc;
    logic [1:0]         w_y;
    logic [22:0]        w_op_vec;
    logic               w_illegal;
    logic               w_in_ready;
    logic               w_accept;

    logic               r_valid;
    logic [22:0]        r_op_vec;
    logic [1:0]         r_x;
    logic [1:0]         r_y;
    logic [7:0]         r_imm;
    logic [7:0]         r_pc;
    logic               r_illegal;
    logic [COUNT_W-1:0] r_count;

    assign w_opc = bus.in_instr[15:12];
    assign w_y   = bus.in_instr[9:8];

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed path would infer a latch.
        w_op_vec  = '0;
        w_illegal = 1'b0;
        case (w_opc)
            4'h0: w_op_vec[OP_NOOP]   = 1'b1;
            4'h1: begin
                case (w_y)
                    2'b00:   w_op_vec[OP_INPUTC]  = 1'b1;
                    2'b01:   w_op_vec[OP_INPUTCF] = 1'b1;
                    2'b10:   w_op_vec[OP_INPUTD]  = 1'b1;
                    default: w_op_vec[OP_INPUTDF] = 1'b1;
                endcase
            end
            4'h2: w_op_vec[OP_MOVE]   = 1'b1;
            4'h3: w_op_vec[OP_LOADI]  = 1'b1;
            4'h4: w_op_vec[OP_ADD]    = 1'b1;
            4'h5: w_op_vec[OP_ADDI]   = 1'b1;
            4'h6: w_op_vec[OP_SUB]    = 1'b1;
            4'h7: w_op_vec[OP_SUBI]   = 1'b1;
            4'h8: w_op_vec[OP_LOAD]   = 1'b1;
            4'h9: w_op_vec[OP_LOADF]  = 1'b1;
            4'hA: w_op_vec[OP_STORE]  = 1'b1;
            4'hB: w_op_vec[OP_STOREF] = 1'b1;
            4'hC: begin
                // Y1=1 in the shift group is reserved: decode as NOOP and flag it.
                case (w_y)
                    2'b00:   w_op_vec[OP_SHIFTL] = 1'b1;
                    2'b01:   w_op_vec[OP_SHIFTR] = 1'b1;
                    default: begin
                        w_op_vec[OP_NOOP] = 1'b1;
                        w_illegal         = 1'b1;
                    end
                endcase
            end
            4'hD: w_op_vec[OP_CMP]    = 1'b1;
            4'hE: w_op_vec[OP_JUMP]   = 1'b1;
            default: begin
                case (w_y)
                    2'b00:   w_op_vec[OP_BRE]  = 1'b1;
                    2'b01:   w_op_vec[OP_BRNE] = 1'b1;
                    2'b10:   w_op_vec[OP_BRG]  = 1'b1;
                    default: w_op_vec[OP_BRGE] = 1'b1;
                endcase
            end
        endcase
    end

    assign w_in_ready = ~bus.flush & (~r_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_op_vec  <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else if (bus.flush) begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            r_valid   <= 1'b0;
            r_op_vec  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op_vec  <= w_op_vec;
            r_x       <= bus.in_instr[11:10];
            r_y       <= w_y;
            r_imm     <= bus.in_instr[7:0];
            r_pc      <= bus.in_pc;
            r_illegal <= w_illegal;
            r_count   <= r_count + COUNT_W'(1);
        end else if (r_valid && bus.out_ready) begin
            // Consumed with nothing behind it: empty, but fields keep their last values.
            r_valid   <= 1'b0;
            r_op_vec  <= '0;
            r_illegal <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.op_vec       = r_op_vec;
    assign bus.out_x        = r_x;
    assign bus.out_y        = r_y;
    assign bus.out_imm      = r_imm;
    assign bus.out_pc       = r_pc;
    assign bus.out_illegal  = r_illegal;
    assign bus.decode_count = r_count;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: a reference decoder feeds a scoreboard
// queue on every accept; a negedge monitor compares the DUT against its head.
module tb_instr_decode_stage;
    localparam int CW = 4;

    typedef struct packed {
        logic [22:0] op;
        logic        illegal;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [7:0]  imm;
        logic [7:0]  pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t          sb[$];
    exp_t          m_last;
    logic [CW-1:0] m_count;

    instr_decode_stage_if #(.COUNT_W(CW)) itf ();

    instr_decode_stage #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (itf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decoder, organised by opcode ranges rather than a per-opcode table.
    function automatic exp_t exp_decode(input logic [15:0] w, input logic [7:0] pc);
        exp_t       e;
        int         idx;
        logic       ill;
        logic [3:0] opc;
        logic [1:0] y;
        opc = w[15:12];
        y   = w[9:8];
        ill = 1'b0;
        if (opc == 4'h0)                       idx = 0;
        else if (opc == 4'h1)                  idx = 1 + int'(y);
        else if (opc >= 4'h2 && opc <= 4'hB)   idx = int'(opc) + 3;
        else if (opc == 4'hC) begin
            if (y[1]) begin idx = 0; ill = 1'b1; end
            else idx = 15 + int'(y[0]);
        end
        else if (opc == 4'hD)                  idx = 17;
        else if (opc == 4'hE)                  idx = 18;
        else                                   idx = 19 + int'(y);
        e.op      = 23'd1 << idx;
        e.illegal = ill;
        e.x       = w[11:10];
        e.y       = y;
        e.imm     = w[7:0];
        e.pc      = pc;
        return e;
    endfunction

    // Scoreboard model: push on accept, pop on consume, clear on flush/reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            m_count = '0;
            m_last  = '0;
        end else begin
            logic rdy;
            exp_t e;
            rdy = !itf.flush && (sb.size() == 0 || itf.out_ready);
            if (itf.flush) begin
                sb.delete();
            end else begin
                if (sb.size() != 0 && itf.out_ready) sb.delete(0);
                if (itf.in_valid && rdy) begin
                    e = exp_decode(itf.in_instr, itf.in_pc);
                    sb.push_back(e);
                    m_last  = e;
                    m_count = m_count + 1'b1;
                end
            end
        end
    end

    // Monitor: compares registered outputs and in_ready away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic        e_rdy;
            logic        e_valid;
            logic [22:0] e_op;
            logic        e_ill;
            e_rdy   = !itf.flush && (sb.size() == 0 || itf.out_ready);
            e_valid = (sb.size() != 0);
            e_op    = e_valid ? sb[0].op : '0;
            e_ill   = e_valid ? sb[0].illegal : 1'b0;
            n_checks += 5;
            if (itf.in_ready !== e_rdy) begin
                n_fail++; $display("FAIL sb_in_ready @%0t: got %0b want %0b", $time, itf.in_ready, e_rdy);
            end
            if (itf.out_valid !== e_valid) begin
                n_fail++; $display("FAIL sb_out_valid @%0t: got %0b want %0b", $time, itf.out_valid, e_valid);
            end
            if (itf.op_vec !== e_op || itf.out_illegal !== e_ill) begin
                n_fail++; $display("FAIL sb_op @%0t: got %h/%0b want %h/%0b", $time, itf.op_vec, itf.out_illegal, e_op, e_ill);
            end
            if ({itf.out_x, itf.out_y, itf.out_imm, itf.out_pc} !== {m_last.x, m_last.y, m_last.imm, m_last.pc}) begin
                n_fail++; $display("FAIL sb_fields @%0t: got x%0d y%0d imm%h pc%h want x%0d y%0d imm%h pc%h", $time,
                    itf.out_x, itf.out_y, itf.out_imm, itf.out_pc, m_last.x, m_last.y, m_last.imm, m_last.pc);
            end
            if (itf.decode_count !== m_count) begin
                n_fail++; $display("FAIL sb_count @%0t: got %0d want %0d", $time, itf.decode_count, m_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic [7:0] pc,
                         input logic ordy, input logic fl);
        itf.in_valid  = v;
        itf.in_instr  = w;
        itf.in_pc     = pc;
        itf.out_ready = ordy;
        itf.flush     = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({itf.out_valid, itf.op_vec, itf.out_x, itf.out_y, itf.out_imm, itf.out_pc,
             itf.out_illegal, itf.decode_count} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got v%0b op%h cnt%0d want all zero", itf.out_valid, itf.op_vec, itf.decode_count);
        end
        n_checks++;
        if (itf.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %0b want 1", itf.in_ready);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, 16'h4900, 8'h12, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (itf.out_valid !== 1'b1 || itf.op_vec !== 23'h000080 || itf.out_x !== 2'd2 ||
            itf.out_y !== 2'd1 || itf.out_pc !== 8'h12 || itf.decode_count !== 4'd1) begin
            n_fail++; $display("FAIL add: got v%0b op%h x%0d y%0d pc%h cnt%0d want v1 op000080 x2 y1 pc12 cnt1",
                itf.out_valid, itf.op_vec, itf.out_x, itf.out_y, itf.out_pc, itf.decode_count);
        end
    endtask

    task automatic test_group_decode();
        logic [15:0] words [4] = '{16'hF205, 16'h1F10, 16'hC100, 16'hC200};
        logic [22:0] ops   [4] = '{23'h200000, 23'h000010, 23'h010000, 23'h000001};
        logic        ills  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 8'(8'h20 + i), 1'b1, 1'b0);
            tick();
            n_checks++;
            if (itf.op_vec !== ops[i] || itf.out_illegal !== ills[i]) begin
                n_fail++; $display("FAIL group_%h: got op%h ill%0b want op%h ill%0b",
                    words[i], itf.op_vec, itf.out_illegal, ops[i], ills[i]);
            end
        end
        n_checks++;
        if (itf.out_y !== 2'd2 || itf.out_x !== 2'd0 || itf.out_imm !== 8'h00) begin
            n_fail++; $display("FAIL illegal_fields: got x%0d y%0d imm%h want x0 y2 imm00", itf.out_x, itf.out_y, itf.out_imm);
        end
        drive(1'b1, 16'hF205, 8'h30, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (itf.out_imm !== 8'h05 || itf.op_vec !== 23'h200000) begin
            n_fail++; $display("FAIL brg_imm: got imm%h op%h want imm05 op200000", itf.out_imm, itf.op_vec);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h2600, 8'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h8177, 8'h41, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (itf.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, itf.in_ready);
            end
            tick();
            n_checks++;
            if (itf.op_vec !== 23'h000020 || itf.out_pc !== 8'h40 || itf.decode_count !== 4'd7) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got op%h pc%h cnt%0d want op000020 pc40 cnt7",
                    i, itf.op_vec, itf.out_pc, itf.decode_count);
            end
        end
        itf.out_ready = 1'b1;
        #1;
        n_checks++;
        if (itf.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %0b want 1", itf.in_ready);
        end
        tick();
        n_checks++;
        if (itf.op_vec !== 23'h000800 || itf.out_pc !== 8'h41 || itf.out_imm !== 8'h77 || itf.decode_count !== 4'd8) begin
            n_fail++; $display("FAIL bp_release_load: got op%h pc%h imm%h cnt%0d want op000800 pc41 imm77 cnt8",
                itf.op_vec, itf.out_pc, itf.out_imm, itf.decode_count);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'hE020, 8'h50, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (itf.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %0b want 0", itf.in_ready);
        end
        tick();
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (itf.out_valid !== 1'b0 || itf.op_vec !== '0 || itf.decode_count !== 4'd8) begin
            n_fail++; $display("FAIL flush_empty: got v%0b op%h cnt%0d want v0 op0 cnt8", itf.out_valid, itf.op_vec, itf.decode_count);
        end
        tick();
        n_checks++;
        if (itf.out_valid !== 1'b0 || itf.out_pc !== 8'h41) begin
            n_fail++; $display("FAIL flush_not_decoded: got v%0b pc%h want v0 pc41", itf.out_valid, itf.out_pc);
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 16'h5000 | 16'(i), 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (itf.decode_count !== 4'd9) begin
            n_fail++; $display("FAIL count_wrap: got %0d want 9", itf.decode_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
            tick();
        end
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'hD3AB, 8'h77, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({itf.out_valid, itf.op_vec, itf.out_x, itf.out_y, itf.out_imm, itf.out_pc,
             itf.out_illegal, itf.decode_count} !== '0) begin
            n_fail++; $display("FAIL async_reset: got v%0b op%h pc%h cnt%0d want all zero",
                itf.out_valid, itf.op_vec, itf.out_pc, itf.decode_count);
        end
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (itf.in_ready !== 1'b1 || itf.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_release: got rdy%0b v%0b want rdy1 v0", itf.in_ready, itf.out_valid);
        end
        drive(1'b1, 16'h0000, 8'h01, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (itf.decode_count !== 4'd1 || itf.op_vec !== 23'h000001) begin
            n_fail++; $display("FAIL post_reset_accept: got cnt%0d op%h want cnt1 op000001", itf.decode_count, itf.op_vec);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_group_decode();
        test_backpressure();
        test_flush();
        test_count_wrap();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
